// File: rtl/sr_cpu.sv
// rtl/sr_cpu.sv - single-cycle RV32 subset core (add/sub/or/srl/sltu/addi/lui/beq/bne)
// Optional mul instruction enabled by defining SR_CPU_MUL_INSTR_EN.
module sr_cpu (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imAddr,
    input  logic [31:0] imData,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_b;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_branch;
    logic [31:0] w_pc_next;
    logic        w_wen;
    logic [31:0] w_wdata;
    logic        w_br_taken;

    assign w_opcode = imData[6:0];
    assign w_rd     = imData[11:7];
    assign w_f3     = imData[14:12];
    assign w_rs1    = imData[19:15];
    assign w_rs2    = imData[24:20];
    assign w_f7     = imData[31:25];

    assign w_imm_i = {{20{imData[31]}}, imData[31:20]};
    assign w_imm_u = {imData[31:12], 12'b0};
    assign w_imm_b = {{20{imData[31]}}, imData[7], imData[30:25], imData[11:8], 1'b0};

    // x0 is forced to zero on read so its storage slot never matters
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    assign regData = (!rst || regAddr == 5'd0) ? 32'd0 : r_regs[regAddr];
    assign imAddr  = {2'b00, r_pc[31:2]};

    always_comb begin
        w_wen      = 1'b0;
        w_wdata    = 32'd0;
        w_br_taken = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                case ({w_f7, w_f3})
                    10'b0000000_000: begin w_wen = 1'b1; w_wdata = w_rs1_val + w_rs2_val; end
                    10'b0100000_000: begin w_wen = 1'b1; w_wdata = w_rs1_val - w_rs2_val; end
                    10'b0000000_110: begin w_wen = 1'b1; w_wdata = w_rs1_val | w_rs2_val; end
                    10'b0000000_101: begin w_wen = 1'b1; w_wdata = w_rs1_val >> w_rs2_val[4:0]; end
                    10'b0000000_011: begin
                        w_wen   = 1'b1;
                        w_wdata = {31'd0, (w_rs1_val < w_rs2_val)};
                    end
`ifdef SR_CPU_MUL_INSTR_EN
                    10'b0000001_000: begin w_wen = 1'b1; w_wdata = w_rs1_val * w_rs2_val; end
`endif
                    default: begin w_wen = 1'b0; w_wdata = 32'd0; end
                endcase
            end
            OPC_OP_IMM: begin
                if (w_f3 == 3'b000) begin
                    w_wen   = 1'b1;
                    w_wdata = w_rs1_val + w_imm_i;
                end
            end
            OPC_LUI: begin
                w_wen   = 1'b1;
                w_wdata = w_imm_u;
            end
            OPC_BRANCH: begin
                if (w_f3 == 3'b000)
                    w_br_taken = (w_rs1_val == w_rs2_val);
                else if (w_f3 == 3'b001)
                    w_br_taken = (w_rs1_val != w_rs2_val);
            end
            default: begin
                w_wen      = 1'b0;
                w_br_taken = 1'b0;
            end
        endcase
    end

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_pc_branch = r_pc + w_imm_b;
    assign w_pc_next   = w_br_taken ? w_pc_branch : w_pc_plus4;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= 32'd0;
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
            if (w_wen && w_rd != 5'd0)
                r_regs[w_rd] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_sr_cpu.sv
// tb/tb_sr_cpu.sv - directed self-checking bench for sr_cpu
module tb_sr_cpu;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imAddr;
    logic [31:0] imData;
    logic [4:0]  regAddr;
    logic [31:0] regData;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rom [0:63];

    sr_cpu dut (
        .clk     (clk),
        .rst     (rst),
        .imAddr  (imAddr),
        .imData  (imData),
        .regAddr (regAddr),
        .regData (regData)
    );

    always #5 clk = ~clk;

    assign imData = (imAddr < 32'd64) ? rom[imAddr[5:0]] : NOP;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_addi(input int imm, input logic [4:0] rs1,
                                             input logic [4:0] rd);
        logic [11:0] i12;
        i12 = imm[11:0];
        return {i12, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm20, input logic [4:0] rd);
        return {imm20, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = NOP;
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic load_fib();
        clear_rom();
        rom[0] = enc_addi(0, 5'd0, 5'd10);
        rom[1] = enc_addi(1, 5'd0, 5'd11);
        rom[2] = enc_addi(32, 5'd0, 5'd12);
        rom[3] = enc_r(7'b0000000, 5'd11, 5'd10, 3'b000, 5'd13);
        rom[4] = enc_r(7'b0000000, 5'd0, 5'd11, 3'b000, 5'd10);
        rom[5] = enc_r(7'b0000000, 5'd0, 5'd13, 3'b000, 5'd11);
        rom[6] = enc_addi(-1, 5'd12, 5'd12);
        rom[7] = enc_b(-16, 5'd0, 5'd12, 3'b001);
        rom[8] = enc_b(0, 5'd0, 5'd0, 3'b000);
    endtask

    task automatic test_reset();
        clear_rom();
        rst = 1'b0;
        regAddr = 5'd10;
        cycle();
        cycle();
        #1;
        n_cmp++;
        if (imAddr !== 32'd0) begin
            n_err++; $display("FAIL reset_imaddr: got %h want 0", imAddr);
        end
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL reset_regdata: got %h want 0", regData);
        end
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++;
            if (imAddr !== 32'(k)) begin
                n_err++; $display("FAIL fetch_seq: got %h want %h", imAddr, 32'(k));
            end
            cycle();
        end
    endtask

    task automatic test_imm();
        clear_rom();
        rom[0] = enc_addi(-1, 5'd0, 5'd10);
        rom[1] = enc_b(0, 5'd0, 5'd0, 3'b000);
        hold_reset();
        regAddr = 5'd10;
        cycle();
        #1;
        n_cmp++;
        if (regData !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL addi_neg: got %h want ffffffff", regData);
        end

        clear_rom();
        rom[0] = enc_addi(31, 5'd0, 5'd11);
        rom[1] = enc_lui(20'h80000, 5'd10);
        rom[2] = enc_r(7'b0000000, 5'd11, 5'd10, 3'b101, 5'd10);
        rom[3] = enc_b(0, 5'd0, 5'd0, 3'b000);
        hold_reset();
        cycle();
        cycle();
        #1;
        n_cmp++;
        if (regData !== 32'h80000000) begin
            n_err++; $display("FAIL lui: got %h want 80000000", regData);
        end
        cycle();
        #1;
        n_cmp++;
        if (regData !== 32'h00000001) begin
            n_err++; $display("FAIL srl31: got %h want 00000001", regData);
        end
    endtask

    task automatic test_alu();
        clear_rom();
        rom[0]  = enc_addi(1, 5'd0, 5'd5);
        rom[1]  = enc_addi(-1, 5'd0, 5'd6);
        rom[2]  = enc_r(7'b0000000, 5'd6, 5'd5, 3'b011, 5'd10);
        rom[3]  = enc_r(7'b0000000, 5'd5, 5'd6, 3'b011, 5'd12);
        rom[4]  = enc_addi(3, 5'd0, 5'd7);
        rom[5]  = enc_addi(5, 5'd0, 5'd8);
        rom[6]  = enc_r(7'b0100000, 5'd8, 5'd7, 3'b000, 5'd13);
        rom[7]  = enc_addi(7, 5'd0, 5'd0);
        rom[8]  = enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd14);
        rom[9]  = enc_addi(32'h0F0, 5'd0, 5'd15);
        rom[10] = enc_addi(32'h00F, 5'd0, 5'd16);
        rom[11] = enc_r(7'b0000000, 5'd16, 5'd15, 3'b110, 5'd17);
        rom[12] = enc_r(7'b0000000, 5'd5, 5'd6, 3'b000, 5'd18);
        rom[13] = enc_b(0, 5'd0, 5'd0, 3'b000);
        hold_reset();
        for (int k = 0; k < 16; k++) cycle();
        regAddr = 5'd10; #1;
        n_cmp++;
        if (regData !== 32'd1) begin
            n_err++; $display("FAIL sltu_true: got %h want 1", regData);
        end
        regAddr = 5'd12; #1;
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL sltu_false: got %h want 0", regData);
        end
        regAddr = 5'd13; #1;
        n_cmp++;
        if (regData !== 32'hFFFFFFFE) begin
            n_err++; $display("FAIL sub: got %h want fffffffe", regData);
        end
        regAddr = 5'd0; #1;
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL x0_read: got %h want 0", regData);
        end
        regAddr = 5'd14; #1;
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL x0_write_ignored: got %h want 0", regData);
        end
        regAddr = 5'd17; #1;
        n_cmp++;
        if (regData !== 32'h000000FF) begin
            n_err++; $display("FAIL or: got %h want 000000ff", regData);
        end
        regAddr = 5'd18; #1;
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL add_wrap: got %h want 0", regData);
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [0:8];
        exp_pc = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd7, 32'd7, 32'd7};
        clear_rom();
        rom[0] = enc_addi(5, 5'd0, 5'd5);
        rom[1] = enc_addi(5, 5'd0, 5'd6);
        rom[2] = enc_b(8, 5'd6, 5'd5, 3'b000);
        rom[3] = enc_addi(1, 5'd0, 5'd10);
        rom[4] = enc_b(8, 5'd6, 5'd5, 3'b001);
        rom[5] = enc_addi(2, 5'd10, 5'd10);
        rom[6] = 32'hFFFFFFFF;
        rom[7] = enc_b(0, 5'd0, 5'd0, 3'b000);
        hold_reset();
        for (int k = 0; k < 9; k++) begin
            #1;
            n_cmp++;
            if (imAddr !== exp_pc[k]) begin
                n_err++; $display("FAIL branch_pc[%0d]: got %h want %h", k, imAddr, exp_pc[k]);
            end
            cycle();
        end
        regAddr = 5'd10; #1;
        n_cmp++;
        if (regData !== 32'd2) begin
            n_err++; $display("FAIL branch_x10: got %h want 2", regData);
        end
        regAddr = 5'd31; #1;
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL illegal_nop: got %h want 0", regData);
        end
    endtask

    task automatic test_factorial();
        logic seen;
        clear_rom();
        rom[0] = enc_addi(1, 5'd0, 5'd10);
        rom[1] = enc_addi(12, 5'd0, 5'd11);
        rom[2] = enc_r(7'b0000001, 5'd11, 5'd10, 3'b000, 5'd10);
        rom[3] = enc_addi(-1, 5'd11, 5'd11);
        rom[4] = enc_b(-8, 5'd0, 5'd11, 3'b001);
        rom[5] = enc_b(0, 5'd0, 5'd0, 3'b000);
        hold_reset();
        regAddr = 5'd10;
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            cycle();
            #1;
            if (regData === 32'h1C8CFC00) seen = 1'b1;
        end
`ifdef SR_CPU_MUL_INSTR_EN
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++; $display("FAIL fact12: got %h want 1c8cfc00", regData);
        end
`else
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL fact12_nomul: got %h want not 1c8cfc00", regData);
        end
        n_cmp++;
        if (regData !== 32'd1) begin
            n_err++; $display("FAIL mul_as_nop: got %h want 1", regData);
        end
`endif
        regAddr = 5'd11; #1;
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL fact_counter: got %h want 0", regData);
        end
    endtask

    task automatic test_fibonacci();
        logic seen;
        load_fib();
        hold_reset();
        regAddr = 5'd10;
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            cycle();
            #1;
            n_cmp++;
            if ($isunknown(imAddr)) begin
                n_err++; $display("FAIL fib_imaddr_x: got %h want known", imAddr);
            end
            if (regData === 32'h00213D05) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++; $display("FAIL fib32: got %h want 00213d05", regData);
        end
    endtask

    task automatic test_reset_midrun();
        logic seen;
        load_fib();
        hold_reset();
        regAddr = 5'd10;
        for (int k = 0; k < 60; k++) cycle();
        rst = 1'b0;
        cycle();
        #1;
        n_cmp++;
        if (imAddr !== 32'd0) begin
            n_err++; $display("FAIL midrun_imaddr: got %h want 0", imAddr);
        end
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL midrun_regdata: got %h want 0", regData);
        end
        rst = 1'b1;
        regAddr = 5'd12; #1;
        n_cmp++;
        if (regData !== 32'd0) begin
            n_err++; $display("FAIL midrun_cleared: got %h want 0", regData);
        end
        regAddr = 5'd10;
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            cycle();
            #1;
            if (regData === 32'h00213D05) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++; $display("FAIL midrun_rerun: got %h want 00213d05", regData);
        end
    endtask

    initial begin
        rst = 1'b0;
        regAddr = 5'd10;
        clear_rom();
        test_reset();
        test_imm();
        test_alu();
        test_branch();
        test_factorial();
        test_fibonacci();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
